// File: rtl/exibe_sequencia_if.sv
// Bus between the sequence display unit, the sequence memory and the LEDs.
// Optional pause input present only when EXIBE_PAUSA_EN is defined.
interface exibe_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] dado;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;
`ifdef EXIBE_PAUSA_EN
    logic              pausa;

    modport master (
        input  iniciar, limite, dado, pausa,
        output endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        output iniciar, limite, dado, pausa,
        input  endereco, leds, ocupado, pronto, db_estado
    );
`else
    modport master (
        input  iniciar, limite, dado,
        output endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        output iniciar, limite, dado,
        input  endereco, leds, ocupado, pronto, db_estado
    );
`endif
endinterface

// File: rtl/exibe_sequencia.sv
// Memory-game sequence display: walks addresses 0..limite, lighting each
// stored value for T_ACESO cycles followed by T_APAGADO dark cycles.
// Optional feature: define EXIBE_PAUSA_EN to add the pausa input, which
// freezes the timer and state while lit or dark.
module exibe_sequencia #(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    exibe_sequencia_if.master       bus
);
    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t           state_q, state_d;
    logic [TW-1:0]     timer_q;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] limite_q;
    logic [DATA_W-1:0] dados_q;
    logic              pausa;
    logic              fim_aceso;
    logic              fim_apagado;

`ifdef EXIBE_PAUSA_EN
    assign pausa = bus.pausa;
`else
    assign pausa = 1'b0;
`endif

    assign fim_aceso   = (timer_q == TW'(T_ACESO - 1));
    assign fim_apagado = (timer_q == TW'(T_APAGADO - 1));

    // State register, asynchronous reset to ocioso.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= OCIOSO;
        else       state_q <= state_d;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d       = OCIOSO;
        bus.leds      = '0;
        bus.ocupado   = 1'b1;
        bus.pronto    = 1'b0;
        bus.db_estado = 4'hF;
        case (state_q)
            OCIOSO: begin
                bus.ocupado   = 1'b0;
                bus.db_estado = 4'd0;
                state_d       = bus.iniciar ? PREPARA : OCIOSO;
            end
            PREPARA: begin
                bus.db_estado = 4'd1;
                state_d       = ACENDE;
            end
            ACENDE: begin
                bus.db_estado = 4'd2;
                bus.leds      = dados_q;
                state_d       = (!pausa && fim_aceso) ? APAGA : ACENDE;
            end
            APAGA: begin
                bus.db_estado = 4'd3;
                if (!pausa && fim_apagado)
                    state_d = (endereco_q == limite_q) ? FIM : PROXIMO;
                else
                    state_d = APAGA;
            end
            PROXIMO: begin
                bus.db_estado = 4'd4;
                state_d       = ACENDE;
            end
            FIM: begin
                bus.db_estado = 4'd5;
                bus.pronto    = 1'b1;
                state_d       = OCIOSO;
            end
            default: begin
                bus.db_estado = 4'hF;
                state_d       = OCIOSO;
            end
        endcase
    end

    // Address, latches and timer. The address moves on the edge that enters
    // prepara/proximo so the async memory read is settled one cycle later,
    // when the value is captured on the edge into acende.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_q <= '0;
            limite_q   <= '0;
            dados_q    <= '0;
            timer_q    <= '0;
        end else begin
            if (state_d == PREPARA && state_q != PREPARA)
                endereco_q <= '0;
            else if (state_d == PROXIMO && state_q != PROXIMO)
                endereco_q <= endereco_q + ADDR_W'(1);

            if (state_q == PREPARA) begin
                limite_q <= bus.limite;
                dados_q  <= bus.dado;
            end else if (state_q == PROXIMO) begin
                dados_q  <= bus.dado;
            end

            case (state_q)
                ACENDE: begin
                    if (!pausa) begin
                        if (fim_aceso)                 timer_q <= '0;
                        else if (timer_q != TW'(T_MAX)) timer_q <= timer_q + TW'(1);
                    end
                end
                APAGA: begin
                    if (!pausa) begin
                        if (fim_apagado)               timer_q <= '0;
                        else if (timer_q != TW'(T_MAX)) timer_q <= timer_q + TW'(1);
                    end
                end
                default: timer_q <= '0;
            endcase
        end
    end

    assign bus.endereco = endereco_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia: an expected per-cycle trace is
// built from the scenario and compared against the DUT outputs each cycle.
// Define EXIBE_PAUSA_EN to also exercise the pause input.
module tb_exibe_sequencia;
    logic clock;
    logic reset;
    logic [3:0] mem [16];

    int unsigned testes;
    int unsigned falhas;

    typedef struct packed {
        logic [3:0] db;
        logic       pronto;
        logic       ocupado;
        logic [3:0] endereco;
        logic [3:0] leds;
    } saida_t;

    saida_t esperado [$];

    exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    exibe_sequencia #(
        .T_ACESO   (4),
        .T_APAGADO (2),
        .ADDR_W    (4),
        .DATA_W    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.dado = mem[bus.endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", testes);
        $fatal(1, "timeout");
    end

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado_v);
        testes++;
        if (obtido !== esperado_v) begin
            falhas++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obtido, esperado_v, $time);
        end
    endtask

    function automatic saida_t observado();
        return {bus.db_estado, bus.pronto, bus.ocupado, bus.endereco, bus.leds};
    endfunction

    function automatic saida_t s(input int db, input int pr, input int oc, input int en, input int le);
        return {4'(db), 1'(pr), 1'(oc), 4'(en), 4'(le)};
    endfunction

    // Expected trace of one display run, starting at the prepara cycle.
    task automatic empilha(input int lim, input int extra, input bit ocioso_final);
        esperado.push_back(s(1, 0, 1, 0, 0));
        for (int i = 0; i <= lim; i++) begin
            for (int k = 0; k < 4 + ((i == 0) ? extra : 0); k++)
                esperado.push_back(s(2, 0, 1, i, int'(mem[i])));
            for (int k = 0; k < 2; k++)
                esperado.push_back(s(3, 0, 1, i, 0));
            if (i < lim)
                esperado.push_back(s(4, 0, 1, i + 1, 0));
        end
        esperado.push_back(s(5, 1, 1, lim, 0));
        if (ocioso_final)
            esperado.push_back(s(0, 0, 0, lim, 0));
    endtask

    task automatic observa(input string tag);
        saida_t e;
        @(negedge clock);
        if (esperado.size() == 0) begin
            verifica({tag, "_fila_vazia"}, 1, 0);
        end else begin
            e = esperado.pop_front();
            verifica(tag, 32'(observado()), 32'(e));
        end
    endtask

    initial begin
        int n;
        testes = 0;
        falhas = 0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.limite  = '0;
`ifdef EXIBE_PAUSA_EN
        bus.pausa   = 1'b0;
`endif

        // 1: reset state
        repeat (2) @(negedge clock);
        verifica("reset", 32'(observado()), 32'(s(0, 0, 0, 0, 0)));
        reset = 1'b0;

        // 2: single value, limite=0
        mem[0] = 4'b0010;
        empilha(0, 0, 1'b1);
        bus.iniciar = 1'b1;
        observa("t2_prepara");
        bus.iniciar = 1'b0;
        while (esperado.size() > 0) observa("t2");

        // 3: four values, limite=3
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        empilha(3, 0, 1'b1);
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        observa("t3_prepara");
        bus.iniciar = 1'b0;
        n = 1;
        while (esperado.size() > 0) begin
            observa("t3");
            n++;
        end
        verifica("t3_ciclos", n, 30);

        // 4: iniciar held, limite changed mid-display -> full run, then restart
        empilha(3, 0, 1'b1);
        empilha(0, 0, 1'b1);
        bus.limite  = 4'd3;
        bus.iniciar = 1'b1;
        observa("t4_prepara");
        n = 1;
        while (esperado.size() > 0) begin
            if (n == 5)  bus.limite  = 4'd0;
            if (n == 32) bus.iniciar = 1'b0;
            observa("t4");
            n++;
        end

        // 5: reset during acende of address 2
        bus.limite = 4'd3;
        empilha(3, 0, 1'b0);
        bus.iniciar = 1'b1;
        observa("t5_prepara");
        bus.iniciar = 1'b0;
        for (int k = 1; k <= 16; k++) observa("t5");
        verifica("t5_em_acende2", 32'(observado()), 32'(s(2, 0, 1, 2, 4)));
        reset = 1'b1;
        #1;
        verifica("t5_reset_imediato", 32'(observado()), 32'(s(0, 0, 0, 0, 0)));
        esperado.delete();
        @(negedge clock);
        reset = 1'b0;
        esperado.push_back(s(0, 0, 0, 0, 0));
        observa("t5_ocioso");
        bus.limite = 4'd0;
        empilha(0, 0, 1'b1);
        bus.iniciar = 1'b1;
        observa("t5_reinicio_prepara");
        bus.iniciar = 1'b0;
        while (esperado.size() > 0) observa("t5_reinicio");

`ifdef EXIBE_PAUSA_EN
        // 6: pause three cycles inside acende
        mem[0] = 4'b0110;
        bus.limite = 4'd0;
        empilha(0, 3, 1'b1);
        bus.iniciar = 1'b1;
        observa("t6_prepara");
        bus.iniciar = 1'b0;
        n = 1;
        while (esperado.size() > 0) begin
            observa("t6");
            if (n == 2) bus.pausa = 1'b1;
            if (n == 5) bus.pausa = 1'b0;
            n++;
        end
        verifica("t6_ciclos", n, 12);
`endif

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
